// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock FIFO slice.
// Both the storage block and the top take their parameter defaults from here.
package sync_fifo_pkg;

    localparam int ASIZE_DEFAULT = 2;
    localparam int DSIZE_DEFAULT = 16;

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage with a synchronous write port and an asynchronous read port.
// The read is asynchronous so the head word can fall through to the output.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int ASIZE = ASIZE_DEFAULT,
    parameter int DSIZE = DSIZE_DEFAULT
) (
    input  logic             wclk,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    // Contents are deliberately not reset; only the pointers define validity.
    logic [DSIZE-1:0] mem [0:DEPTH-1];

    always_ff @(posedge wclk) begin
        if (wclken) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO of 2**ASIZE words.
// Binary pointers carry one extra wrap bit so full and empty differ without a counter.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int ASIZE = ASIZE_DEFAULT,
    parameter int DSIZE = DSIZE_DEFAULT
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             w_en,
    input  logic             r_en,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             wfull
);

    localparam int PTR_W = ASIZE + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE-1:0] raddr;
    logic             wr_fire;
    logic             rd_fire;

    assign waddr = wptr[ASIZE-1:0];
    assign raddr = rptr[ASIZE-1:0];

    // Flags come straight from the registered pointers, so they move in the
    // same cycle as the pointer that caused them.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                    (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

    // Requests against a full or empty FIFO are simply dropped.
    assign wr_fire = w_en && !wfull;
    assign rd_fire = r_en && !rempty;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr <= '0;
        end else if (wr_fire) begin
            wptr <= wptr + PTR_W'(1);
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rptr <= '0;
        end else if (rd_fire) begin
            rptr <= rptr + PTR_W'(1);
        end
    end

    fifo_mem #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
    ) fifomem (
        .wclk   (wclk),
        .wclken (wr_fire),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (raddr),
        .rdata  (rdata)
    );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (ASIZE=2, DSIZE=16) with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sync_fifo;

    logic        wclk;
    logic        wrst_n;
    logic [15:0] wdata;
    logic        w_en;
    logic        r_en;
    logic [15:0] rdata;
    logic        rempty;
    logic        wfull;

    int errors = 0;
    int checks = 0;

    sync_fifo #(
        .ASIZE (2),
        .DSIZE (16)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .wdata  (wdata),
        .w_en   (w_en),
        .r_en   (r_en),
        .rdata  (rdata),
        .rempty (rempty),
        .wfull  (wfull)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock transaction; prints one line describing it.
    task automatic cycle(input logic we, input logic [15:0] wd, input logic re);
        w_en  = we;
        wdata = wd;
        r_en  = re;
        @(posedge wclk);
        #1;
        $display("t=%0t w_en=%0b wdata=%h r_en=%0b -> wptr=%0d rptr=%0d rdata=%h rempty=%0b wfull=%0b",
                 $time, we, wd, re, dut.wptr, dut.rptr, rdata, rempty, wfull);
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    logic [15:0] fill [0:3];
    logic [15:0] more [0:3];

    initial begin
        fill[0] = 16'hAAAA; fill[1] = 16'hBBBB; fill[2] = 16'hCCCC; fill[3] = 16'hDDDD;
        more[0] = 16'hEEEE; more[1] = 16'hFFFF; more[2] = 16'h1111; more[3] = 16'h2222;

        wrst_n = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        wdata  = '0;
        #12 wrst_n = 1'b1;

        // 1. reset state
        cycle(1'b0, 16'h0, 1'b0);
        check_eq("rst_rempty", 32'(rempty), 32'd1);
        check_eq("rst_wfull", 32'(wfull), 32'd0);
        check_eq("rst_wptr", 32'(dut.wptr), 32'd0);
        check_eq("rst_rptr", 32'(dut.rptr), 32'd0);

        // 2. fill to full, head falls through after the first write
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, fill[i], 1'b0);
            if (i == 0) begin
                check_eq("fwft_head", 32'(rdata), 32'(fill[0]));
                check_eq("fwft_rempty", 32'(rempty), 32'd0);
            end
        end
        check_eq("fill_wfull", 32'(wfull), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("fill_mem%0d", i), 32'(dut.fifomem.mem[i]), 32'(fill[i]));
        end
        cycle(1'b1, 16'hEEEE, 1'b0);
        check_eq("drop_wptr", 32'(dut.wptr), 32'd4);
        check_eq("drop_mem0", 32'(dut.fifomem.mem[0]), 32'(fill[0]));
        check_eq("drop_wfull", 32'(wfull), 32'd1);

        // 3. read three words
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rd_%0d", i), 32'(rdata), 32'(fill[i]));
            cycle(1'b0, 16'h0, 1'b1);
        end
        check_eq("rd3_rptr", 32'(dut.rptr), 32'd3);
        check_eq("rd3_rdata", 32'(rdata), 32'(fill[3]));
        check_eq("rd3_rempty", 32'(rempty), 32'd0);
        check_eq("rd3_wfull", 32'(wfull), 32'd0);

        // 4. one word (D) held, so only three of E,F,G,H fit; addresses wrap to 0..2
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, more[i], 1'b0);
        end
        check_eq("wrap_wfull", 32'(wfull), 32'd1);
        check_eq("wrap_wptr", 32'(dut.wptr), 32'd7);
        check_eq("wrap_mem0", 32'(dut.fifomem.mem[0]), 32'(more[0]));
        check_eq("wrap_mem3", 32'(dut.fifomem.mem[3]), 32'(fill[3]));
        check_eq("drain_0", 32'(rdata), 32'(fill[3]));
        cycle(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("drain_%0d", i + 1), 32'(rdata), 32'(more[i]));
            check_eq($sformatf("drain_ne%0d", i + 1), 32'(rempty), 32'd0);
            cycle(1'b0, 16'h0, 1'b1);
        end
        check_eq("drain_rempty", 32'(rempty), 32'd1);
        check_eq("drain_rptr", 32'(dut.rptr), 32'd7);
        cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b1);
        check_eq("under_rptr", 32'(dut.rptr), 32'd7);
        check_eq("under_rempty", 32'(rempty), 32'd1);

        // 5. half occupancy, simultaneous read/write; wptr wraps 7->0 here
        cycle(1'b1, 16'h5000, 1'b0);
        cycle(1'b1, 16'h5001, 1'b0);
        check_eq("half_wptr", 32'(dut.wptr), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("rw_data%0d", k), 32'(rdata), 32'(16'h5000 + 16'(k)));
            cycle(1'b1, 16'h5000 + 16'(k + 2), 1'b1);
            check_eq($sformatf("rw_flags%0d", k), {30'd0, rempty, wfull}, 32'd0);
        end
        check_eq("rw_wptr", 32'(dut.wptr), 32'd3);
        check_eq("rw_rptr", 32'(dut.rptr), 32'd1);
        check_eq("rw_head", 32'(rdata), 32'h500A);

        // 6. fill to full, then asynchronous reset between edges
        cycle(1'b1, 16'h6000, 1'b0);
        cycle(1'b1, 16'h6001, 1'b0);
        check_eq("pre_rst_wfull", 32'(wfull), 32'd1);
        #3 wrst_n = 1'b0;
        #1;
        check_eq("arst_rempty", 32'(rempty), 32'd1);
        check_eq("arst_wfull", 32'(wfull), 32'd0);
        check_eq("arst_wptr", 32'(dut.wptr), 32'd0);
        check_eq("arst_rptr", 32'(dut.rptr), 32'd0);
        #2 wrst_n = 1'b1;
        cycle(1'b1, 16'h7777, 1'b0);
        check_eq("post_rst_mem0", 32'(dut.fifomem.mem[0]), 32'h7777);
        check_eq("post_rst_wptr", 32'(dut.wptr), 32'd1);
        check_eq("post_rst_rdata", 32'(rdata), 32'h7777);
        check_eq("post_rst_rempty", 32'(rempty), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sync_fifo
